// File: rtl/usr_shift_reg.sv
// usr_shift_reg: parametrised universal shift register with counted burst mode.
//
// Build option: define USR_ROTATE_EN to enable rotate-left (100) and
// rotate-right (101), both as single ops and as burst ops. With it undefined,
// those codes act as hold and cannot start a burst.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (priority over everything)
//   en      operation enable; low holds register and burst progress
//   mode    3-bit operation select
//   sin_l   serial input into bit 0 on shift left
//   sin_r   serial input into bit N-1 on logical shift right
//   pin     parallel load data
//   start   burst request, honoured in IDLE with en=1 and a shift/rotate mode
//   cnt     burst length in operations
//   out     register contents
//   sout_l  out[N-1]
//   sout_r  out[0]
//   busy    high while a burst is running
//   done    one-cycle burst-complete pulse
module usr_shift_reg #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          sin_l,
    input  logic          sin_r,
    input  logic [N-1:0]  pin,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    output logic [N-1:0]  out,
    output logic          sout_l,
    output logic          sout_r,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [CW-1:0] rem_q;

    // Next register value for one operation.
    function automatic logic [N-1:0] apply_op(
        input logic [2:0]   op,
        input logic [N-1:0] v,
        input logic         sl,
        input logic         sr,
        input logic [N-1:0] p
    );
        logic [N-1:0] r;
        r = v;
        case (op)
            3'b001:  r = {v[N-2:0], sl};
            3'b010:  r = {sr, v[N-1:1]};
            3'b011:  r = p;
`ifdef USR_ROTATE_EN
            3'b100:  r = {v[N-2:0], v[N-1]};
            3'b101:  r = {v[0], v[N-1:1]};
`endif
            3'b110:  r = {v[N-1], v[N-1:1]};
            3'b111:  r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    // Modes that may be repeated as a counted burst.
    function automatic logic burst_ok(input logic [2:0] op);
        logic ok;
        ok = (op == 3'b001) || (op == 3'b010) || (op == 3'b110);
`ifdef USR_ROTATE_EN
        ok = ok || (op == 3'b100) || (op == 3'b101);
`endif
        return ok;
    endfunction

    // Control FSM and datapath register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            op_q  <= '0;
            rem_q <= '0;
        end else begin
            done <= 1'b0;
            if (en) begin
                if (state == IDLE) begin
                    if (start && burst_ok(mode)) begin
                        // Start edge only latches the op; register is untouched.
                        op_q  <= mode;
                        rem_q <= cnt;
                        if (cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        out <= apply_op(mode, out, sin_l, sin_r, pin);
                    end
                end else begin
                    out   <= apply_op(op_q, out, sin_l, sin_r, pin);
                    rem_q <= rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign sout_l = out[N-1];
    assign sout_r = out[0];

endmodule
